cdc_mcp_scheduler: RTL and testbench

Round-robin scheduler that shares one multi-cycle-path toggle CDC channel between NUM_REQ requesters in the source clock domain. It accepts one word at a time over valid/ready handshakes, drives the channel's data and single-cycle sync pulse, and holds the data stable until the crossing has completed. The next grant is blocked until then. It sits directly in front of the MCP toggle synchronizer on the domain-A side.

---
 rtl/cdc_mcp_scheduler.sv | 146 ++++++++++++++
 tb/tb_cdc_mcp_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_mcp_scheduler.sv
// Round-robin front end for a multi-cycle-path toggle CDC channel: grants one requester at a time,
// pulses SYNC_O once and holds DATA_O until the crossing is done. Optional ACK mode: CDC_MCP_SCHED_ACK_EN.
module cdc_mcp_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 5,
    parameter int HOLD_CYCLES = 8,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NUM_REQ-1:0]       REQ_VALID_I,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA_I,
    output logic [NUM_REQ-1:0]       REQ_READY_O,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     SYNC_O,
    output logic [IDW-1:0]           SRC_ID_O,
    output logic                     BUSY_O
`ifdef CDC_MCP_SCHED_ACK_EN
    ,
    input  logic                     ACK_I
`endif
);

    // ST_HOLD is the fixed-length hold, or the wait for ACK_I in ACK mode
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDW-1:0]     src_id_q, src_id_d;
    logic               sync_q, sync_d;
    logic               busy_q, busy_d;

`ifndef CDC_MCP_SCHED_ACK_EN
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    logic [CW-1:0]      cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0]   req_data [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data[gi]     = REQ_DATA_I[gi*WIDTH +: WIDTH];
            assign grant_onehot[gi] = grant_vld && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Search begins one past the last winner, wrapping at NUM_REQ
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(last_grant_q) + 1 + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld && REQ_VALID_I[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        src_id_d     = src_id_q;
        sync_d       = 1'b0;
`ifndef CDC_MCP_SCHED_ACK_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    data_d       = req_data[grant_idx];
                    src_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    sync_d       = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
`ifndef CDC_MCP_SCHED_ACK_EN
                cnt_d   = CW'(HOLD_CYCLES - 1);
`endif
            end
            ST_HOLD: begin
`ifdef CDC_MCP_SCHED_ACK_EN
                if (ACK_I) begin
                    state_d = ST_IDLE;
                end
`else
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            data_q       <= '0;
            src_id_q     <= '0;
            sync_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifndef CDC_MCP_SCHED_ACK_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            src_id_q     <= src_id_d;
            sync_q       <= sync_d;
            busy_q       <= busy_d;
`ifndef CDC_MCP_SCHED_ACK_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign REQ_READY_O = (state_q == ST_IDLE) ? grant_onehot : '0;
    assign DATA_O      = data_q;
    assign SRC_ID_O    = src_id_q;
    assign SYNC_O      = sync_q;
    assign BUSY_O      = busy_q;

endmodule

// File: tb/tb_cdc_mcp_scheduler.sv
// Directed bench for cdc_mcp_scheduler (NUM_REQ=4, WIDTH=5, HOLD_CYCLES=8); ACK scenarios
// run instead of the hold scenarios when CDC_MCP_SCHED_ACK_EN is defined.
module tb_cdc_mcp_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [19:0] data_in;
    logic [3:0]  ready;
    logic [4:0]  data;
    logic        sync;
    logic [1:0]  src;
    logic        busy;
`ifdef CDC_MCP_SCHED_ACK_EN
    logic        ack;
`endif

    int n_vec = 0;
    int n_err = 0;

    cdc_mcp_scheduler #(
        .NUM_REQ    (4),
        .WIDTH      (5),
        .HOLD_CYCLES(8)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .REQ_VALID_I(valid),
        .REQ_DATA_I (data_in),
        .REQ_READY_O(ready),
        .DATA_O     (data),
        .SYNC_O     (sync),
        .SRC_ID_O   (src),
        .BUSY_O     (busy)
`ifdef CDC_MCP_SCHED_ACK_EN
        ,
        .ACK_I      (ack)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifndef CDC_MCP_SCHED_ACK_EN
    // Entered in handshake cycle t; returns just after the edge that starts t+10
    task automatic grant(input logic [3:0] er, input int eid, input logic [4:0] ed,
                         input logic [3:0] v_after, input logic [3:0] v_mid);
        settle();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("ready_grant", 32'(ready), 32'(er));
        cyc();
        valid = v_after;
        settle();
        chk("sync_pulse", 32'(sync), 32'd1);
        chk("data_issue", 32'(data), 32'(ed));
        chk("src_issue", 32'(src), 32'(eid));
        chk("busy_issue", 32'(busy), 32'd1);
        chk("ready_issue", 32'(ready), 32'd0);
        for (int c = 2; c <= 9; c++) begin
            cyc();
            if (c == 5) valid = v_mid;
            settle();
            chk("sync_hold", 32'(sync), 32'd0);
            chk("data_hold", 32'(data), 32'(ed));
            chk("src_hold", 32'(src), 32'(eid));
            chk("busy_hold", 32'(busy), 32'd1);
            chk("ready_hold", 32'(ready), 32'd0);
        end
        cyc();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        valid   = 4'b0000;
        data_in = {5'h1E, 5'h15, 5'h0A, 5'h01};
`ifdef CDC_MCP_SCHED_ACK_EN
        ack     = 1'b0;
`endif
        repeat (3) cyc();
        rst = 1'b0;

        // Idle after reset: everything quiet for 20 cycles
        for (int c = 0; c < 20; c++) begin
            cyc();
            settle();
            chk("idle_outputs", 32'({ready, sync, data, src, busy}), 32'd0);
        end

`ifndef CDC_MCP_SCHED_ACK_EN
        // All four valid: order 0,1,2,3,0; then 1 drops mid-hold while 3 waits
        valid = 4'b1111;
        grant(4'b0001, 0, 5'h01, 4'b1111, 4'b1111);
        grant(4'b0010, 1, 5'h0A, 4'b1111, 4'b1111);
        grant(4'b0100, 2, 5'h15, 4'b1111, 4'b1111);
        grant(4'b1000, 3, 5'h1E, 4'b1111, 4'b1111);
        grant(4'b0001, 0, 5'h01, 4'b1010, 4'b1000);
        grant(4'b1000, 3, 5'h1E, 4'b0000, 4'b0000);

        // Lone requester 2 keeps valid: regranted no earlier than t+10
        valid = 4'b0100;
        grant(4'b0100, 2, 5'h15, 4'b0100, 4'b0100);
        grant(4'b0100, 2, 5'h15, 4'b0000, 4'b0000);

        // Reset while the hold counter is at 4
        valid = 4'b0010;
        settle();
        chk("rst_pre_ready", 32'(ready), 32'b0010);
        cyc();
        valid = 4'b0000;
        settle();
        chk("rst_pre_sync", 32'(sync), 32'd1);
        chk("rst_pre_src", 32'(src), 32'd1);
        repeat (4) cyc();
        rst = 1'b1;
        settle();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        cyc();
        rst = 1'b0;
        settle();
        chk("rst_outputs", 32'({ready, sync, data, src, busy}), 32'd0);
        valid = 4'b1111;
        grant(4'b0001, 0, 5'h01, 4'b0000, 4'b0000);
`else
        // ACK during ISSUE ignored; ACK 13 cycles after handshake ends the crossing
        valid = 4'b0001;
        settle();
        chk("ack_ready", 32'(ready), 32'b0001);
        cyc();
        valid = 4'b0000;
        ack   = 1'b1;
        settle();
        chk("ack_sync", 32'(sync), 32'd1);
        cyc();
        ack = 1'b0;
        settle();
        chk("ack_issue_ignored", 32'(busy), 32'd1);
        valid = 4'b0010;
        for (int c = 3; c <= 12; c++) begin
            cyc();
            settle();
            chk("ack_wait_busy", 32'(busy), 32'd1);
            chk("ack_wait_ready", 32'(ready), 32'd0);
        end
        cyc();
        ack = 1'b1;
        settle();
        chk("ack_last_busy", 32'(busy), 32'd1);
        cyc();
        ack = 1'b0;
        settle();
        chk("ack_idle_busy", 32'(busy), 32'd0);
        chk("ack_idle_ready", 32'(ready), 32'b0010);
        cyc();
        valid = 4'b0000;
        settle();
        chk("ack_sync2", 32'(sync), 32'd1);
        chk("ack_src2", 32'(src), 32'd1);
        for (int c = 0; c < 30; c++) begin
            cyc();
            settle();
            chk("noack_busy", 32'(busy), 32'd1);
            chk("noack_sync", 32'(sync), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
